// File: rtl/hit_reaction_ctrl_pkg.sv
// ============================================================================
// Module      : hit_reaction_ctrl_pkg
// Description : Shared state encoding and default timing/health values for
//               the hit reaction controller, HUD and movement FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hit_reaction_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HITSTUN   = 2'd1,
        BLOCKSTUN = 2'd2,
        KO        = 2'd3
    } state_t;

    localparam int C_MAX_HEALTH            = 3;
    localparam int C_HEALTH_W              = 3;
    localparam int C_HITSTUN_FRAMES        = 20;
    localparam int C_DIRATK_HITSTUN_FRAMES = 28;
    localparam int C_BLOCKSTUN_FRAMES      = 12;
    localparam int C_DIRATK_DAMAGE         = 2;
    localparam int C_CNT_W                 = 6;

endpackage

`default_nettype wire

// File: rtl/hit_reaction_ctrl_edge_pulse.sv
// ============================================================================
// Module      : edge_pulse
// Description : 1-bit rising-edge detector; rise is high in the first cycle
//               that din is seen high after being low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= din;
        end
    end

    assign rise = din & ~r_q;

endmodule

`default_nettype wire

// File: rtl/hit_reaction_ctrl.sv
// ============================================================================
// Module      : hit_reaction_ctrl
// Description : Per-player hit/block event handling, stun timing, health and KO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hit_reaction_ctrl
    import hit_reaction_ctrl_pkg::*;
#(
    parameter int MAX_HEALTH            = C_MAX_HEALTH,
    parameter int HEALTH_W              = C_HEALTH_W,
    parameter int HITSTUN_FRAMES        = C_HITSTUN_FRAMES,
    parameter int DIRATK_HITSTUN_FRAMES = C_DIRATK_HITSTUN_FRAMES,
    parameter int BLOCKSTUN_FRAMES      = C_BLOCKSTUN_FRAMES,
    parameter int DIRATK_DAMAGE         = C_DIRATK_DAMAGE,
    parameter int CNT_W                 = C_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                round_reset,
    input  logic                got_hit,
    input  logic                got_blocked,
    input  logic                attacker_diratk_flag,
    output logic                in_hitstun,
    output logic                in_blockstun,
    output logic                stun_active,
    output logic [HEALTH_W-1:0] health,
    output logic                ko,
    output logic                hit_pulse,
    output logic                block_pulse
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [HEALTH_W-1:0] r_health;
    logic [HEALTH_W-1:0] w_health_nxt;
    logic [HEALTH_W-1:0] w_dmg;
    logic                w_hit_rise;
    logic                w_blk_rise;
    logic                w_hit_pulse_nxt;
    logic                w_blk_pulse_nxt;
    logic                r_in_hitstun;
    logic                r_in_blockstun;
    logic                r_ko;
    logic                r_hit_pulse;
    logic                r_block_pulse;

    edge_pulse u_hit_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (got_hit),
        .rise (w_hit_rise)
    );

    edge_pulse u_blk_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (got_blocked),
        .rise (w_blk_rise)
    );

    assign w_dmg = attacker_diratk_flag ? HEALTH_W'(DIRATK_DAMAGE) : HEALTH_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_health_nxt    = r_health;
        w_hit_pulse_nxt = 1'b0;
        w_blk_pulse_nxt = 1'b0;
        if (round_reset) begin
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
            w_health_nxt = HEALTH_W'(MAX_HEALTH);
        end else begin
            case (r_state)
                IDLE: begin
                    // A simultaneous block edge is dropped: the hit takes precedence.
                    if (w_hit_rise) begin
                        w_hit_pulse_nxt = 1'b1;
                        if (r_health > w_dmg) begin
                            w_health_nxt = r_health - w_dmg;
                            w_state_nxt  = HITSTUN;
                            w_cnt_nxt    = attacker_diratk_flag ? CNT_W'(DIRATK_HITSTUN_FRAMES)
                                                                : CNT_W'(HITSTUN_FRAMES);
                        end else begin
                            w_health_nxt = '0;
                            w_state_nxt  = KO;
                            w_cnt_nxt    = '0;
                        end
                    end else if (w_blk_rise) begin
                        w_blk_pulse_nxt = 1'b1;
                        w_state_nxt     = BLOCKSTUN;
                        w_cnt_nxt       = CNT_W'(BLOCKSTUN_FRAMES);
                    end
                end
                HITSTUN, BLOCKSTUN: begin
                    if (frame_tick) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                KO: begin
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_health       <= HEALTH_W'(MAX_HEALTH);
            r_hit_pulse    <= 1'b0;
            r_block_pulse  <= 1'b0;
            r_in_hitstun   <= 1'b0;
            r_in_blockstun <= 1'b0;
            r_ko           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_health       <= w_health_nxt;
            r_hit_pulse    <= w_hit_pulse_nxt;
            r_block_pulse  <= w_blk_pulse_nxt;
            r_in_hitstun   <= (w_state_nxt == HITSTUN);
            r_in_blockstun <= (w_state_nxt == BLOCKSTUN);
            r_ko           <= (w_state_nxt == KO);
        end
    end

    assign in_hitstun   = r_in_hitstun;
    assign in_blockstun = r_in_blockstun;
    assign stun_active  = (r_state == HITSTUN) || (r_state == BLOCKSTUN);
    assign health       = r_health;
    assign ko           = r_ko;
    assign hit_pulse    = r_hit_pulse;
    assign block_pulse  = r_block_pulse;

endmodule

`default_nettype wire

// File: tb/tb_hit_reaction_ctrl.sv
// ============================================================================
// Module      : tb_hit_reaction_ctrl
// Description : Self-checking bench for hit_reaction_ctrl with a pulse scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hit_reaction_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       round_reset = 1'b0;
    logic       got_hit = 1'b0;
    logic       got_blocked = 1'b0;
    logic       attacker_diratk_flag = 1'b0;
    logic       in_hitstun;
    logic       in_blockstun;
    logic       stun_active;
    logic [2:0] health;
    logic       ko;
    logic       hit_pulse;
    logic       block_pulse;

    always #5 clk = ~clk;

    hit_reaction_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .frame_tick           (frame_tick),
        .round_reset          (round_reset),
        .got_hit              (got_hit),
        .got_blocked          (got_blocked),
        .attacker_diratk_flag (attacker_diratk_flag),
        .in_hitstun           (in_hitstun),
        .in_blockstun         (in_blockstun),
        .stun_active          (stun_active),
        .health               (health),
        .ko                   (ko),
        .hit_pulse            (hit_pulse),
        .block_pulse          (block_pulse)
    );

    typedef struct {
        bit is_hit;
        int health;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hit_cnt  = 0;
    int   blk_cnt  = 0;

    // Behavioural reference: 0=IDLE 1=HITSTUN 2=BLOCKSTUN 3=KO
    int m_state  = 0;
    int m_health = 3;
    int m_cnt    = 0;
    bit m_hq     = 1'b0;
    bit m_bq     = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: advance the model with the current inputs, clock the DUT, compare.
    task automatic cycle();
        bit   hr;
        bit   br;
        int   dmg;
        exp_t e;
        hr = got_hit & ~m_hq;
        br = got_blocked & ~m_bq;
        if (rst) begin
            m_state = 0; m_health = 3; m_cnt = 0; m_hq = 0; m_bq = 0;
        end else begin
            m_hq = got_hit;
            m_bq = got_blocked;
            if (round_reset) begin
                m_state = 0; m_health = 3; m_cnt = 0;
            end else if (m_state == 0) begin
                if (hr) begin
                    dmg = attacker_diratk_flag ? 2 : 1;
                    if (m_health > dmg) begin
                        m_health -= dmg;
                        m_state = 1;
                        m_cnt = attacker_diratk_flag ? 28 : 20;
                    end else begin
                        m_health = 0; m_state = 3; m_cnt = 0;
                    end
                    e.is_hit = 1'b1; e.health = m_health;
                    sb_q.push_back(e);
                end else if (br) begin
                    m_state = 2; m_cnt = 12;
                    e.is_hit = 1'b0; e.health = m_health;
                    sb_q.push_back(e);
                end
            end else if (m_state == 1 || m_state == 2) begin
                if (frame_tick) begin
                    if (m_cnt == 1) begin
                        m_state = 0; m_cnt = 0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        hit_cnt += int'(hit_pulse);
        blk_cnt += int'(block_pulse);
        check("in_hitstun", int'(in_hitstun), int'(m_state == 1));
        check("in_blockstun", int'(in_blockstun), int'(m_state == 2));
        check("stun_active", int'(stun_active), int'(m_state == 1 || m_state == 2));
        check("ko", int'(ko), int'(m_state == 3));
        check("health", int'(health), m_health);
        if (hit_pulse || block_pulse) begin
            check("pulse_exclusive", int'(hit_pulse && block_pulse), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind_hit", int'(hit_pulse), int'(e.is_hit));
                check("pulse_health", int'(health), e.health);
            end
        end
        if (sb_q.size() != 0) begin
            check("missed_pulse", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; cycle();
            frame_tick = 1'b0; idle_cycles(3);
        end
    endtask

    // Drive frame ticks until the stun ends or max_ticks counted stun ticks are applied.
    task automatic run_stun(input int inject_tick, input int max_ticks, output int ticks);
        int guard;
        guard = 0;
        ticks = 0;
        while (stun_active && ticks < max_ticks && guard < 2000) begin
            frame_tick = (guard % 4 == 3);
            got_hit = (inject_tick >= 0 && ticks == inject_tick && guard % 4 == 1);
            if (frame_tick) ticks++;
            cycle();
            guard++;
        end
        frame_tick = 1'b0;
        got_hit = 1'b0;
        if (guard >= 2000) check("stun_timeout", 1, 0);
    endtask

    task automatic do_round_reset();
        round_reset = 1'b1; cycle();
        round_reset = 1'b0; cycle();
    endtask

    initial begin
        int ticks;
        int h0;
        int b0;

        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        check("reset_health", int'(health), 3);
        check("reset_pulses", int'(hit_pulse) + int'(block_pulse), 0);

        // Idle frames: nothing happens
        frames(10);
        check("idle_no_pulse", hit_cnt + blk_cnt, 0);

        // Held hit, normal attack
        h0 = hit_cnt;
        got_hit = 1'b1; idle_cycles(5);
        got_hit = 1'b0;
        check("t2_one_hit", hit_cnt - h0, 1);
        check("t2_health", int'(health), 2);
        run_stun(-1, 1000, ticks);
        check("t2_hitstun_ticks", ticks, 20);
        idle_cycles(2);

        // Held block, hit inside blockstun ignored
        do_round_reset();
        h0 = hit_cnt; b0 = blk_cnt;
        got_blocked = 1'b1; idle_cycles(3);
        got_blocked = 1'b0;
        run_stun(5, 1000, ticks);
        check("t3_blockstun_ticks", ticks, 12);
        check("t3_one_block", blk_cnt - b0, 1);
        check("t3_no_hit", hit_cnt - h0, 0);
        check("t3_health", int'(health), 3);
        idle_cycles(2);

        // Simultaneous hit and block with directional attack
        h0 = hit_cnt; b0 = blk_cnt;
        got_hit = 1'b1; got_blocked = 1'b1; attacker_diratk_flag = 1'b1;
        cycle();
        got_hit = 1'b0; got_blocked = 1'b0; attacker_diratk_flag = 1'b0;
        cycle();
        check("t4_hit_only", hit_cnt - h0, 1);
        check("t4_no_block", blk_cnt - b0, 0);
        check("t4_health", int'(health), 1);
        run_stun(-1, 1000, ticks);
        check("t4_diratk_ticks", ticks, 28);
        idle_cycles(2);

        // KO from health 1
        h0 = hit_cnt;
        got_hit = 1'b1; attacker_diratk_flag = 1'b1; cycle();
        got_hit = 1'b0; attacker_diratk_flag = 1'b0; cycle();
        check("t5_health_zero", int'(health), 0);
        check("t5_ko", int'(ko), 1);
        check("t5_no_hitstun", int'(in_hitstun), 0);
        got_hit = 1'b1; cycle();
        got_hit = 1'b0; cycle();
        frames(2);
        check("t5_ko_hits", hit_cnt - h0, 1);
        do_round_reset();
        check("t5_rr_health", int'(health), 3);
        check("t5_rr_ko", int'(ko), 0);

        // round_reset mid-hitstun at counter 7
        got_hit = 1'b1; cycle();
        got_hit = 1'b0; cycle();
        run_stun(-1, 13, ticks);
        check("t6_mid_ticks", ticks, 13);
        check("t6_still_stunned", int'(in_hitstun), 1);
        round_reset = 1'b1; cycle();
        round_reset = 1'b0;
        check("t6_rr_hitstun", int'(in_hitstun), 0);
        check("t6_rr_health", int'(health), 3);

        // rst together with got_hit
        h0 = hit_cnt;
        rst = 1'b1; got_hit = 1'b1; cycle();
        rst = 1'b0; got_hit = 1'b0; cycle();
        check("t6_rst_no_pulse", hit_cnt - h0, 0);
        check("t6_rst_health", int'(health), 3);
        idle_cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
